// File: rtl/ltc2195_pkg.sv
// ltc2195_pkg: shared LTC2195 link constants, types and the lane bit map.
package ltc2195_pkg;
  localparam int LTC_FRAME_BITS = 8;
  localparam int LTC_LANES = 2;
  localparam int LTC_WORD_W = 16;
  typedef logic [LTC_WORD_W-1:0] word_t;
  typedef struct packed {
    word_t ch1;
    word_t ch0;
  } pair_t;
  // Frame bit k carries w[15-2k] on lane 1 and w[14-2k] on lane 0, MSB first.
  function automatic logic [3:0] bit_of(input logic [2:0] k, input logic lane);
    return 4'(LTC_WORD_W - 2 + int'(lane) - 2 * int'(k));
  endfunction
endpackage

// File: rtl/ltc2195_tx_emulator_if.sv
// ltc2195_tx_emulator_if: sample-pair handshake into the LTC2195 transmit emulator.
interface ltc2195_tx_emulator_if;
  logic [15:0] ch0_in;
  logic [15:0] ch1_in;
  logic sample_valid;
  logic sample_ready;
  logic train_in;
  modport master(output ch0_in, ch1_in, sample_valid, train_in, input sample_ready);
  modport slave(input ch0_in, ch1_in, sample_valid, train_in, output sample_ready);
endinterface

// File: rtl/ltc2195_tx_emulator_lane_serializer.sv
// ltc_lane_serializer: holds one channel word and drives its two lanes, one bit pair per strobe.
module ltc_lane_serializer
  import ltc2195_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 strobe,
  input  logic [2:0]           k,
  input  word_t                din,
  output logic [LTC_LANES-1:0] lanes
);
  word_t word;
  always_ff @(posedge clk)
    if (rst) begin
      word  <= '0;
      lanes <= '0;
    end else if (load) begin
      word  <= din;
      lanes <= {din[bit_of(3'd0, 1'b1)], din[bit_of(3'd0, 1'b0)]};
    end else if (strobe)
      lanes <= {word[bit_of(k, 1'b1)], word[bit_of(k, 1'b0)]};
endmodule

// File: rtl/ltc2195_tx_emulator.sv
// ltc2195_tx_emulator: serialises channel sample pairs onto DCO/FR/D0/D1 like an LTC2195 ADC.
module ltc2195_tx_emulator
  import ltc2195_pkg::*;
#(
  parameter int          DIV       = 8,
  parameter logic [15:0] TRAIN_PAT = 16'hA55A
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  ltc2195_tx_emulator_if.slave  s,
  output logic                  dco_out,
  output logic                  fr_out,
  output logic [LTC_LANES-1:0]  d0_out,
  output logic [LTC_LANES-1:0]  d1_out,
  output logic                  frame_out,
  output logic                  underrun_out
);
  localparam int DW = $clog2(DIV);
  localparam int BW = $clog2(LTC_FRAME_BITS);
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic full, loaded, start, strobe, consume, xfer, full_next;
  pair_t buf_q, last, word;
  assign strobe    = div_cnt == '0;
  assign start     = strobe && bit_cnt == '0;
  assign consume   = start && full && !s.train_in;
  assign xfer      = s.sample_valid && s.sample_ready;
  assign full_next = xfer || (full && !consume);
  always_comb word = s.train_in ? {TRAIN_PAT, TRAIN_PAT} : full ? buf_q : last;
  always_ff @(posedge clk_in)
    if (rst_in) begin
      div_cnt        <= '0;
      bit_cnt        <= '0;
      full           <= 1'b0;
      loaded         <= 1'b0;
      buf_q          <= '0;
      last           <= '0;
      s.sample_ready <= 1'b1;
      dco_out        <= 1'b0;
      fr_out         <= 1'b0;
      frame_out      <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      div_cnt        <= div_cnt == DW'(DIV - 1) ? '0 : div_cnt + 1'b1;
      bit_cnt        <= div_cnt == DW'(DIV - 1) ? bit_cnt + 1'b1 : bit_cnt;
      dco_out        <= div_cnt == DW'(DIV / 2) ? ~dco_out : dco_out;
      fr_out         <= strobe ? ~bit_cnt[BW-1] : fr_out;
      frame_out      <= start;
      last           <= consume ? buf_q : last;
      loaded         <= loaded || consume;
      underrun_out   <= underrun_out || (start && !s.train_in && !full && loaded);
      buf_q          <= xfer ? {s.ch1_in, s.ch0_in} : buf_q;
      full           <= full_next;
      s.sample_ready <= !full_next;
    end
  ltc_lane_serializer u_ser0 (
    .clk(clk_in), .rst(rst_in), .load(start), .strobe(strobe), .k(bit_cnt),
    .din(word.ch0), .lanes(d0_out)
  );
  ltc_lane_serializer u_ser1 (
    .clk(clk_in), .rst(rst_in), .load(start), .strobe(strobe), .k(bit_cnt),
    .din(word.ch1), .lanes(d1_out)
  );
endmodule
